// File: rtl/sbox_arbiter.sv
// Shares one external combinational S-box between AES-128 key expansion (SubWord with optional RotWord)
// and the round datapath (SubBytes), granting round-robin and streaming one byte per cycle.
module sbox_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         kx_req,
    input  logic         kx_rot,
    input  logic [31:0]  kx_word,
    output logic         kx_done,
    output logic [31:0]  kx_result,
    input  logic         rd_req,
    input  logic [127:0] rd_state,
    output logic         rd_done,
    output logic [127:0] rd_result,
    output logic         busy,
    output logic [7:0]   sbox_in,
    input  logic [7:0]   sbox_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} ArbState;

    ArbState      state;
    ArbState      nextState;
    logic         ownerRd;
    logic         lastOwnerRd;
    logic [3:0]   cnt;
    logic [3:0]   lastIdx;
    logic [127:0] operand;
    logic [31:0]  kxOperand;
    logic         grantKx;
    logic         grantRd;

    // On a tie the requester that did not hold the previous grant wins; a lone request always wins.
    assign grantKx   = kx_req && (!rd_req || lastOwnerRd);
    assign grantRd   = rd_req && (!kx_req || !lastOwnerRd);
    assign kxOperand = kx_rot ? {kx_word[23:0], kx_word[31:24]} : kx_word;
    assign lastIdx   = ownerRd ? 4'd15 : 4'd3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (kx_req || rd_req) nextState = RUN;
            RUN:     if (cnt == lastIdx) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        kx_done = (state == DONE) && !ownerRd;
        rd_done = (state == DONE) && ownerRd;
        sbox_in = (state == RUN) ? operand[127:120] : 8'h00;
    end

    // The operand shifts left so the current byte is always on top; the key word sits in the upper 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 4'd0;
            operand     <= 128'h0;
            ownerRd     <= 1'b0;
            lastOwnerRd <= 1'b1;
            kx_result   <= 32'h0;
            rd_result   <= 128'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantKx) begin
                        operand     <= {kxOperand, 96'h0};
                        ownerRd     <= 1'b0;
                        lastOwnerRd <= !lastOwnerRd;
                        cnt         <= 4'd0;
                    end else if (grantRd) begin
                        operand     <= rd_state;
                        ownerRd     <= 1'b1;
                        lastOwnerRd <= !lastOwnerRd;
                        cnt         <= 4'd0;
                    end
                end
                RUN: begin
                    operand <= {operand[119:0], 8'h00};
                    cnt     <= cnt + 4'd1;
                    if (ownerRd) begin
                        for (int i = 0; i < 16; i++) begin
                            if (cnt == 4'(i)) rd_result[(15-i)*8 +: 8] <= sbox_out;
                        end
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            if (cnt == 4'(i)) kx_result[(3-i)*8 +: 8] <= sbox_out;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_arbiter.sv
// Self-checking bench for sbox_arbiter: directed AES vectors plus randomized transactions
// checked against a table-driven SubWord/SubBytes and round-robin reference model.
module tb_sbox_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         kx_req;
    logic         kx_rot;
    logic [31:0]  kx_word;
    logic         kx_done;
    logic [31:0]  kx_result;
    logic         rd_req;
    logic [127:0] rd_state;
    logic         rd_done;
    logic [127:0] rd_result;
    logic         busy;
    logic [7:0]   sbox_in;
    logic [7:0]   sbox_out;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0]  expKx;
    logic [127:0] expRd;
    logic         lastRd;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [31:0] rotIf(input logic [31:0] w, input logic rot);
        return rot ? {w[23:0], w[31:24]} : w;
    endfunction

    function automatic logic [31:0] refKx(input logic [31:0] w, input logic rot);
        logic [31:0] op;
        logic [31:0] r;
        op = rotIf(w, rot);
        for (int k = 0; k < 4; k++) r[31-8*k -: 8] = sbox(op[31-8*k -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] refRd(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
        return r;
    endfunction

    assign sbox_out = sbox(sbox_in);

    always #5 clk = ~clk;

    sbox_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .kx_req(kx_req), .kx_rot(kx_rot), .kx_word(kx_word),
        .kx_done(kx_done), .kx_result(kx_result),
        .rd_req(rd_req), .rd_state(rd_state),
        .rd_done(rd_done), .rd_result(rd_result),
        .busy(busy), .sbox_in(sbox_in), .sbox_out(sbox_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset;
        expKx  = 32'h0;
        expRd  = 128'h0;
        lastRd = 1'b1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        kx_req   = 1'($urandom);
        rd_req   = 1'($urandom);
        kx_rot   = 1'($urandom);
        kx_word  = $urandom;
        rd_state = {$urandom, $urandom, $urandom, $urandom};
        modelReset();
        #3;
        for (int r = 0; r < 2; r++) begin
            assertCount += 4;
            if ({kx_done, rd_done, busy} !== 3'b000) begin
                failCount++;
                $display("[TB] FAIL reset_flags got %b exp 000", {kx_done, rd_done, busy});
            end
            if (kx_result !== 32'h0) begin
                failCount++;
                $display("[TB] FAIL reset_kx_result got %h exp 0", kx_result);
            end
            if (rd_result !== 128'h0) begin
                failCount++;
                $display("[TB] FAIL reset_rd_result got %h exp 0", rd_result);
            end
            if (sbox_in !== 8'h0) begin
                failCount++;
                $display("[TB] FAIL reset_sbox_in got %h exp 0", sbox_in);
            end
            tick();
        end
        kx_req = 1'b0;
        rd_req = 1'b0;
        rst_n  = 1'b1;
        tick();
        assertCount++;
        if (busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL idle_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_kx_only;
        kx_req  = 1'b1;
        kx_rot  = 1'b1;
        kx_word = 32'h09CF4F3C;
        rd_req  = 1'b0;
        lastRd  = !lastRd;
        for (int c = 1; c <= 6; c++) begin
            tick();
            assertCount += 4;
            if (kx_done !== (c == 5)) begin
                failCount++;
                $display("[TB] FAIL kx_only_done c=%0d got %b exp %b", c, kx_done, c == 5);
            end
            if (rd_done !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL kx_only_rd_done c=%0d got %b exp 0", c, rd_done);
            end
            if (busy !== (c <= 5)) begin
                failCount++;
                $display("[TB] FAIL kx_only_busy c=%0d got %b exp %b", c, busy, c <= 5);
            end
            if (rd_result !== expRd) begin
                failCount++;
                $display("[TB] FAIL kx_only_rd_result c=%0d got %h exp %h", c, rd_result, expRd);
            end
            if (c == 5) begin
                expKx = 32'h8A84EB01;
                assertCount++;
                if (kx_result !== expKx) begin
                    failCount++;
                    $display("[TB] FAIL kx_only_result got %h exp %h", kx_result, expKx);
                end
                kx_req = 1'b0;
            end
        end
    endtask

    task automatic test_rd_only;
        logic [127:0] s;
        s        = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
        rd_req   = 1'b1;
        rd_state = s;
        lastRd   = !lastRd;
        for (int c = 1; c <= 18; c++) begin
            tick();
            assertCount += 4;
            if (rd_done !== (c == 17) || kx_done !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL rd_only_done c=%0d got rd=%b kx=%b exp rd=%b kx=0", c, rd_done, kx_done, c == 17);
            end
            if (busy !== (c <= 17)) begin
                failCount++;
                $display("[TB] FAIL rd_only_busy c=%0d got %b exp %b", c, busy, c <= 17);
            end
            if (sbox_in !== ((c <= 16) ? s[127-8*(c-1) -: 8] : 8'h00)) begin
                failCount++;
                $display("[TB] FAIL rd_only_sbox_in c=%0d got %h", c, sbox_in);
            end
            if (kx_result !== expKx) begin
                failCount++;
                $display("[TB] FAIL rd_only_kx_result c=%0d got %h exp %h", c, kx_result, expKx);
            end
            if (c == 17) begin
                expRd = 128'hD42711AEE0BF98F1B8B45DE51E415230;
                assertCount++;
                if (rd_result !== expRd) begin
                    failCount++;
                    $display("[TB] FAIL rd_only_result got %h exp %h", rd_result, expRd);
                end
                rd_req = 1'b0;
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [127:0] s1;
        logic [31:0]  w2;
        logic         rot2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        modelReset();
        s1       = {$urandom, $urandom, $urandom, $urandom};
        w2       = $urandom;
        rot2     = 1'($urandom);
        kx_req   = 1'b1;
        kx_rot   = 1'b0;
        kx_word  = 32'h0;
        rd_req   = 1'b1;
        rd_state = s1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            assertCount += 3;
            if (kx_done !== (c == 5 || c == 29)) begin
                failCount++;
                $display("[TB] FAIL simul_kx_done c=%0d got %b", c, kx_done);
            end
            if (rd_done !== (c == 23)) begin
                failCount++;
                $display("[TB] FAIL simul_rd_done c=%0d got %b", c, rd_done);
            end
            if (busy !== !(c == 6 || c == 24 || c == 30)) begin
                failCount++;
                $display("[TB] FAIL simul_busy c=%0d got %b", c, busy);
            end
            if (c == 5) begin
                expKx = 32'h63636363;
                assertCount++;
                if (kx_result !== expKx) begin
                    failCount++;
                    $display("[TB] FAIL simul_kx_result got %h exp %h", kx_result, expKx);
                end
                kx_req = 1'b0;
            end
            if (c == 6) begin
                kx_req  = 1'b1;
                kx_word = w2;
                kx_rot  = rot2;
            end
            if (c == 23) begin
                expRd = refRd(s1);
                assertCount++;
                if (rd_result !== expRd) begin
                    failCount++;
                    $display("[TB] FAIL simul_rd_result got %h exp %h", rd_result, expRd);
                end
                rd_req = 1'b0;
            end
            if (c == 29) begin
                expKx = refKx(w2, rot2);
                assertCount++;
                if (kx_result !== expKx) begin
                    failCount++;
                    $display("[TB] FAIL simul_kx_result2 got %h exp %h", kx_result, expKx);
                end
                kx_req = 1'b0;
            end
        end
        lastRd = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [127:0] s1;
        logic [127:0] s2;
        s1       = {$urandom, $urandom, $urandom, $urandom};
        s2       = {$urandom, $urandom, $urandom, $urandom};
        rd_req   = 1'b1;
        rd_state = s1;
        for (int c = 1; c <= 36; c++) begin
            tick();
            assertCount += 2;
            if (rd_done !== (c == 17 || c == 35)) begin
                failCount++;
                $display("[TB] FAIL b2b_rd_done c=%0d got %b", c, rd_done);
            end
            if (busy !== !(c == 18 || c == 36)) begin
                failCount++;
                $display("[TB] FAIL b2b_busy c=%0d got %b", c, busy);
            end
            if (c == 17 || c == 35) begin
                expRd = refRd(c == 17 ? s1 : s2);
                assertCount++;
                if (rd_result !== expRd) begin
                    failCount++;
                    $display("[TB] FAIL b2b_rd_result c=%0d got %h exp %h", c, rd_result, expRd);
                end
                rd_state = s2;
            end
            if (c == 35) rd_req = 1'b0;
        end
        lastRd = !lastRd;
        lastRd = !lastRd;
    endtask

    task automatic test_reset_mid_run;
        logic [127:0] s;
        s        = {$urandom, $urandom, $urandom, $urandom};
        rd_req   = 1'b1;
        rd_state = s;
        for (int c = 1; c <= 8; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        assertCount += 3;
        if ({kx_done, rd_done, busy} !== 3'b000 || sbox_in !== 8'h0) begin
            failCount++;
            $display("[TB] FAIL midreset_flags got %b sbox_in=%h exp 000 00", {kx_done, rd_done, busy}, sbox_in);
        end
        if (kx_result !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL midreset_kx_result got %h exp 0", kx_result);
        end
        if (rd_result !== 128'h0) begin
            failCount++;
            $display("[TB] FAIL midreset_rd_result got %h exp 0", rd_result);
        end
        tick();
        rst_n  = 1'b1;
        lastRd = !lastRd;
        for (int c = 1; c <= 18; c++) begin
            tick();
            assertCount += 2;
            if (rd_done !== (c == 17)) begin
                failCount++;
                $display("[TB] FAIL midreset_rd_done c=%0d got %b", c, rd_done);
            end
            if (busy !== (c <= 17)) begin
                failCount++;
                $display("[TB] FAIL midreset_busy c=%0d got %b", c, busy);
            end
            if (c == 17) begin
                expRd = refRd(s);
                assertCount++;
                if (rd_result !== expRd) begin
                    failCount++;
                    $display("[TB] FAIL midreset_rd_result2 got %h exp %h", rd_result, expRd);
                end
                rd_req = 1'b0;
            end
        end
    endtask

    task automatic test_drop_mid_run;
        logic [31:0] w;
        logic        rot;
        w       = $urandom;
        rot     = 1'($urandom);
        kx_req  = 1'b1;
        kx_word = w;
        kx_rot  = rot;
        lastRd  = !lastRd;
        for (int c = 1; c <= 6; c++) begin
            tick();
            assertCount += 2;
            if (kx_done !== (c == 5)) begin
                failCount++;
                $display("[TB] FAIL drop_kx_done c=%0d got %b", c, kx_done);
            end
            if (busy !== (c <= 5)) begin
                failCount++;
                $display("[TB] FAIL drop_busy c=%0d got %b", c, busy);
            end
            if (c == 2) begin
                kx_req  = 1'b0;
                kx_word = ~w;
                kx_rot  = ~rot;
            end
            if (c == 5) begin
                expKx = refKx(w, rot);
                assertCount++;
                if (kx_result !== expKx) begin
                    failCount++;
                    $display("[TB] FAIL drop_kx_result got %h exp %h", kx_result, expKx);
                end
            end
        end
    endtask

    task automatic test_random;
        logic         kxOn;
        logic         rdOn;
        logic         winRd;
        logic [31:0]  w;
        logic         rot;
        logic [127:0] s;
        logic [127:0] opBytes;
        int           n;
        for (int t = 0; t < 24; t++) begin
            kxOn = 1'($urandom);
            rdOn = 1'($urandom);
            if (!kxOn && !rdOn) kxOn = 1'b1;
            w     = $urandom;
            rot   = 1'($urandom);
            s     = {$urandom, $urandom, $urandom, $urandom};
            winRd = (kxOn && rdOn) ? !lastRd : rdOn;
            lastRd  = !lastRd;
            n       = winRd ? 16 : 4;
            opBytes = winRd ? s : {rotIf(w, rot), 96'h0};
            kx_req   = kxOn;
            rd_req   = rdOn;
            kx_word  = w;
            kx_rot   = rot;
            rd_state = s;
            for (int c = 1; c <= n + 1; c++) begin
                tick();
                kx_word  = $urandom;
                kx_rot   = 1'($urandom);
                rd_state = {$urandom, $urandom, $urandom, $urandom};
                assertCount += 3;
                if ({kx_done, rd_done} !== ((c == n + 1) ? {!winRd, winRd} : 2'b00)) begin
                    failCount++;
                    $display("[TB] FAIL rand_done t=%0d c=%0d got kx=%b rd=%b winRd=%b", t, c, kx_done, rd_done, winRd);
                end
                if (busy !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL rand_busy t=%0d c=%0d got %b exp 1", t, c, busy);
                end
                if (sbox_in !== ((c <= n) ? opBytes[127-8*(c-1) -: 8] : 8'h00)) begin
                    failCount++;
                    $display("[TB] FAIL rand_sbox_in t=%0d c=%0d got %h", t, c, sbox_in);
                end
            end
            if (winRd) expRd = refRd(s);
            else       expKx = refKx(w, rot);
            assertCount += 2;
            if (kx_result !== expKx) begin
                failCount++;
                $display("[TB] FAIL rand_kx_result t=%0d got %h exp %h", t, kx_result, expKx);
            end
            if (rd_result !== expRd) begin
                failCount++;
                $display("[TB] FAIL rand_rd_result t=%0d got %h exp %h", t, rd_result, expRd);
            end
            kx_req = 1'b0;
            rd_req = 1'b0;
            tick();
            assertCount++;
            if (busy !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL rand_idle_busy t=%0d got %b exp 0", t, busy);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before the test sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_kx_only();
        test_rd_only();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_run();
        test_drop_mid_run();
        test_random();
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
